// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Responder for the core's data-memory port. Decodes the MEM-stage
//   address/strobe and returns load data combinationally. Holds a
//   word-addressed data RAM and an MMIO window with an LED register, a
//   free-running cycle counter and a small TX byte FIFO. The FIFO drains
//   through a valid/ready stream.
//
// Ports
//   CLK        in   system clock, rising edge
//   Reset      in   synchronous, active-high reset
//   MemWrite   in   store strobe
//   Addr       in   byte address; bits [1:0] ignored
//   WriteData  in   store data
//   ReadData   out  load data, combinational from Addr
//   led        out  LED register
//   tx_valid   out  TX FIFO non-empty
//   tx_data    out  TX FIFO head byte (0 when empty)
//   tx_ready   in   consumer accepts head when tx_valid && tx_ready

module data_mem_responder #(
    parameter int unsigned RAM_WORDS  = 128,
    parameter logic [31:0] MMIO_BASE  = 32'h0000_0800,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        MemWrite,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic [15:0] led,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready
);

    localparam int unsigned AW        = $clog2(RAM_WORDS);
    localparam int unsigned PW        = $clog2(FIFO_DEPTH);
    localparam logic [31:0] RAM_BYTES = 32'(4 * RAM_WORDS);

    typedef enum logic [1:0] {
        REG_LED    = 2'd0,
        REG_CYCLES = 2'd1,
        REG_TXDATA = 2'd2,
        REG_STATUS = 2'd3
    } mmio_reg_e;

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [31:0]   ram [RAM_WORDS];
    logic [31:0]   cycles;
    logic          overflow;
    logic [7:0]    fifo_buf [FIFO_DEPTH];
    logic [PW:0]   wr_ptr;
    logic [PW:0]   rd_ptr;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic          is_ram;
    logic          is_mmio;
    mmio_reg_e     reg_sel;
    logic [AW-1:0] ram_idx;

    assign is_ram  = (Addr < RAM_BYTES);
    assign is_mmio = (Addr[31:4] == MMIO_BASE[31:4]);
    assign reg_sel = mmio_reg_e'(Addr[3:2]);
    assign ram_idx = Addr[AW+1:2];

    // ------------------------------------------------------------------
    // FIFO status and handshake
    // ------------------------------------------------------------------
    logic [PW:0]   count;
    logic          full;
    logic          empty;
    logic          pop;
    logic          push_req;
    logic          push;
    logic          drop;

    // Extra wrap bit on each pointer makes the difference the true fill level.
    assign count    = wr_ptr - rd_ptr;
    assign full     = (count == (PW+1)'(FIFO_DEPTH));
    assign empty    = (count == '0);
    assign tx_valid = !empty;
    assign tx_data  = empty ? '0 : fifo_buf[rd_ptr[PW-1:0]];

    assign pop      = tx_valid && tx_ready;
    assign push_req = MemWrite && is_mmio && (reg_sel == REG_TXDATA);
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push     = push_req && (!full || pop);
    assign drop     = push_req && full && !pop;

    // ------------------------------------------------------------------
    // RAM (not affected by Reset)
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (MemWrite && is_ram) begin
            ram[ram_idx] <= WriteData;
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            fifo_buf[wr_ptr[PW-1:0]] <= WriteData[7:0];
        end
    end

    // ------------------------------------------------------------------
    // MMIO registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (Reset) begin
            led      <= '0;
            cycles   <= '0;
            overflow <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            cycles <= cycles + 32'd1;

            if (MemWrite && is_mmio && (reg_sel == REG_LED)) begin
                led <= WriteData[15:0];
            end

            // Drop sets overflow ahead of a STATUS-write clear.
            if (drop) begin
                overflow <= 1'b1;
            end else if (MemWrite && is_mmio && (reg_sel == REG_STATUS)) begin
                overflow <= 1'b0;
            end

            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    always_comb begin
        ReadData = '0;
        if (is_ram) begin
            ReadData = ram[ram_idx];
        end else if (is_mmio) begin
            unique case (reg_sel)
                REG_LED:    ReadData = {16'b0, led};
                REG_CYCLES: ReadData = cycles;
                REG_TXDATA: ReadData = '0;
                REG_STATUS: ReadData = {23'b0, overflow, 4'(count), 2'b0, full, empty};
                default:    ReadData = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder
//   Directed scenarios followed by a randomized run, every cycle compared
//   against a behavioural model (array RAM, byte queue FIFO).

module tb_data_mem_responder;

    localparam logic [31:0] A_LED = 32'h800;
    localparam logic [31:0] A_CYC = 32'h804;
    localparam logic [31:0] A_TXD = 32'h808;
    localparam logic [31:0] A_STS = 32'h80C;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        MemWrite;
    logic [31:0] Addr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic [15:0] led;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;

    always #5 CLK = ~CLK;

    data_mem_responder #(
        .RAM_WORDS (128),
        .MMIO_BASE (32'h0000_0800),
        .FIFO_DEPTH(4)
    ) dut (
        .CLK      (CLK),
        .Reset    (Reset),
        .MemWrite (MemWrite),
        .Addr     (Addr),
        .WriteData(WriteData),
        .ReadData (ReadData),
        .led      (led),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_ready (tx_ready)
    );

    // Behavioural model
    logic [31:0] m_ram [128];
    bit          m_ok  [128];
    logic [15:0] m_led;
    logic [31:0] m_cycles;
    bit          m_ovf;
    logic [7:0]  m_q [$];
    bit          m_valid = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [31:0] a);
        logic [31:0] r;
        int unsigned n;
        r = '0;
        n = m_q.size();
        if (a < 32'h200) begin
            r = m_ram[a[8:2]];
        end else if (a[31:4] == 28'h080) begin
            case (a[3:2])
                2'd0: r = {16'h0, m_led};
                2'd1: r = m_cycles;
                2'd2: r = '0;
                default: r = {23'b0, m_ovf, 4'(n), 2'b0, n == 4, n == 0};
            endcase
        end
        return r;
    endfunction

    // One bus cycle: drive, check against model before the edge, advance model.
    task automatic cycle(input logic rst, input logic we, input logic [31:0] a,
                         input logic [31:0] wd, input logic rdy,
                         input string tag = "", input logic [31:0] exp = '0);
        bit pop_m, acc, drop;
        Reset = rst; MemWrite = we; Addr = a; WriteData = wd; tx_ready = rdy;
        #1;
        if (m_valid) begin
            if (!(a < 32'h200 && !m_ok[a[8:2]]))
                chk("rdata", ReadData, m_read(a));
            chk("tx_valid", 32'(tx_valid), 32'(m_q.size() != 0));
            chk("tx_data", 32'(tx_data), (m_q.size() != 0) ? 32'(m_q[0]) : 32'h0);
            chk("led", 32'(led), 32'(m_led));
        end
        if (tag != "") chk(tag, ReadData, exp);
        @(posedge CLK);
        if (rst) begin
            m_led = '0; m_cycles = '0; m_ovf = 1'b0; m_q.delete(); m_valid = 1'b1;
        end else begin
            pop_m = (m_q.size() != 0) && rdy;
            acc = 1'b0; drop = 1'b0;
            m_cycles = m_cycles + 32'd1;
            if (we) begin
                if (a < 32'h200) begin
                    m_ram[a[8:2]] = wd; m_ok[a[8:2]] = 1'b1;
                end else if (a[31:4] == 28'h080) begin
                    case (a[3:2])
                        2'd0: m_led = wd[15:0];
                        2'd2: if (m_q.size() < 4 || pop_m) acc = 1'b1; else drop = 1'b1;
                        2'd3: m_ovf = 1'b0;
                        default: ;
                    endcase
                end
            end
            if (pop_m) void'(m_q.pop_front());
            if (acc) m_q.push_back(wd[7:0]);
            if (drop) m_ovf = 1'b1;
        end
        #1;
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        case ($urandom_range(0, 9))
            0, 1, 2: a = 32'($urandom_range(0, 127)) << 2;
            3:       a = A_LED;
            4:       a = A_CYC;
            5, 6:    a = A_TXD;
            7:       a = A_STS;
            8:       a = 32'h200 + (32'($urandom_range(0, 200)) << 2);
            default: a = $urandom();
        endcase
        a[1:0] = 2'($urandom_range(0, 3));
        return a;
    endfunction

    logic [7:0] exp_bytes [4];

    initial begin
        for (int i = 0; i < 128; i++) m_ok[i] = 1'b0;
        Reset = 1'b1; MemWrite = 1'b0; Addr = '0; WriteData = '0; tx_ready = 1'b0;
        @(posedge CLK); #1;

        // Reset state
        cycle(1, 0, A_STS, 0, 0);
        chk("rst_valid", 32'(tx_valid), 32'h0);
        chk("rst_led", 32'(led), 32'h0);
        cycle(0, 0, A_STS, 0, 0, "rst_status", 32'h1);

        // RAM write then read-back, neighbour untouched
        cycle(0, 1, 32'h014, 32'h1234_5678, 0);
        cycle(0, 1, 32'h010, 32'hDEAD_BEEF, 0);
        cycle(0, 0, 32'h010, 0, 0, "t1_ram", 32'hDEAD_BEEF);
        cycle(0, 0, 32'h014, 0, 0, "t1_neigh", 32'h1234_5678);

        // LED register and unmapped read
        cycle(0, 1, A_LED, 32'h0001_A5A5, 0);
        chk("t2_led", 32'(led), 32'h0000_A5A5);
        cycle(0, 0, A_LED, 0, 0, "t2_rd", 32'h0000_A5A5);
        cycle(0, 0, 32'h7FC, 0, 0, "t2_unmapped", 32'h0);

        // Cycle counter after reset
        cycle(1, 0, A_CYC, 0, 0);
        cycle(0, 0, A_CYC, 0, 0, "t3_c0", 32'd0);
        for (int i = 0; i < 9; i++) cycle(0, 0, A_CYC, 0, 0);
        cycle(0, 0, A_CYC, 0, 0, "t3_c10", 32'd10);

        // Fill, overflow, drain in order
        for (int i = 1; i <= 5; i++) cycle(0, 1, A_TXD, 32'(i * 8'h11), 0);
        cycle(0, 0, A_STS, 0, 0, "t4_status", 32'h142);
        exp_bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) begin
            chk("t4_pop", 32'(tx_data), 32'(exp_bytes[i]));
            cycle(0, 0, A_STS, 0, 1);
        end
        cycle(0, 0, A_STS, 0, 0, "t4_empty", 32'h101);

        // Push into full FIFO while popping
        cycle(0, 1, A_STS, 0, 0);
        for (int i = 1; i <= 4; i++) cycle(0, 1, A_TXD, 32'(i * 8'h11), 0);
        cycle(0, 1, A_TXD, 32'h66, 1);
        cycle(0, 0, A_STS, 0, 0, "t5_status", 32'h042);
        exp_bytes = '{8'h22, 8'h33, 8'h44, 8'h66};
        for (int i = 0; i < 4; i++) begin
            chk("t5_pop", 32'(tx_data), 32'(exp_bytes[i]));
            cycle(0, 0, A_STS, 0, 1);
        end

        // Reset mid-stream
        for (int i = 0; i < 3; i++) cycle(0, 1, A_TXD, 32'hA1 + 32'(i), 0);
        chk("t6_pre_valid", 32'(tx_valid), 32'h1);
        cycle(1, 0, A_STS, 0, 0);
        chk("t6_valid", 32'(tx_valid), 32'h0);
        chk("t6_led", 32'(led), 32'h0);
        cycle(0, 0, A_STS, 0, 0, "t6_status", 32'h1);
        cycle(0, 0, 32'h010, 0, 0, "t6_ram", 32'hDEAD_BEEF);

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            logic rst, we, rdy;
            rst = ($urandom_range(0, 199) == 0);
            we  = rst ? 1'b0 : 1'($urandom_range(0, 1));
            rdy = ((i / 300) % 2 == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 1);
            cycle(rst, we, rand_addr(), $urandom(), rdy);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
